// File: rtl/ahb_gpio_param_if.sv
// AHB-Lite bus signals between the decoder/mux and the GPIO slave.
interface ahb_gpio_param_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_gpio_param.sv
// Parametrised AHB-Lite GPIO slave: direction/data registers, synchronised inputs,
// per-bit edge interrupts with a write-1-to-clear status register.
module ahb_gpio_param #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_gpio_param_if.slave       ahb,
  input  logic [GPIO_WIDTH-1:0] GPIOIN,
  output logic [GPIO_WIDTH-1:0] GPIOOUT,
  output logic [GPIO_WIDTH-1:0] GPIOOE,
  output logic                  GPIOINT
);

  logic                  r_valid;
  logic [4:0]            r_addr;
  logic                  r_write;
  logic [2:0]            r_size;

  logic [GPIO_WIDTH-1:0] r_dout;
  logic [GPIO_WIDTH-1:0] r_dir;
  logic [GPIO_WIDTH-1:0] r_inten;
  logic [GPIO_WIDTH-1:0] r_intpol;
  logic [GPIO_WIDTH-1:0] r_intstat;
  logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] r_prev;

  logic [3:0]            w_lanes;
  logic [31:0]           w_bmask32;
  logic [GPIO_WIDTH-1:0] w_wmask;
  logic [GPIO_WIDTH-1:0] w_wdata;
  logic                  w_wr;
  logic                  w_wrDout;
  logic                  w_wrDir;
  logic                  w_wrInten;
  logic                  w_wrIntpol;
  logic                  w_wrStat;
  logic [GPIO_WIDTH-1:0] w_w1c;
  logic [GPIO_WIDTH-1:0] w_din;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_fall;
  logic [GPIO_WIDTH-1:0] w_ev;
  logic [31:0]           w_rdmux;
  logic                  w_unused;

  // Address phase capture; the data phase always completes on the next edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else if (ahb.HSEL && ahb.HREADY && ahb.HTRANS[1]) begin
      r_valid <= 1'b1;
      r_addr  <= ahb.HADDR[4:0];
      r_write <= ahb.HWRITE;
      r_size  <= ahb.HSIZE;
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_lanes = 4'b0000;
    case (r_size[1:0])
      2'd0:    w_lanes = 4'b0001 << r_addr[1:0];
      2'd1:    w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  assign w_bmask32  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
  assign w_wmask    = w_bmask32[GPIO_WIDTH-1:0];
  assign w_wdata    = ahb.HWDATA[GPIO_WIDTH-1:0];
  assign w_wr       = r_valid & r_write;
  assign w_wrDout   = w_wr && (r_addr[4:2] == 3'd0);
  assign w_wrDir    = w_wr && (r_addr[4:2] == 3'd1);
  assign w_wrInten  = w_wr && (r_addr[4:2] == 3'd3);
  assign w_wrIntpol = w_wr && (r_addr[4:2] == 3'd4);
  assign w_wrStat   = w_wr && (r_addr[4:2] == 3'd5);
  assign w_w1c      = w_wrStat ? (w_wdata & w_wmask) : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout   <= '0;
      r_dir    <= '0;
      r_inten  <= '0;
      r_intpol <= '0;
    end else begin
      if (w_wrDout)   r_dout   <= (r_dout   & ~w_wmask) | (w_wdata & w_wmask);
      if (w_wrDir)    r_dir    <= (r_dir    & ~w_wmask) | (w_wdata & w_wmask);
      if (w_wrInten)  r_inten  <= (r_inten  & ~w_wmask) | (w_wdata & w_wmask);
      if (w_wrIntpol) r_intpol <= (r_intpol & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= GPIOIN;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_din;
    end
  end

  assign w_din  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_din & ~r_prev;
  assign w_fall = ~w_din & r_prev;
  assign w_ev   = ((r_intpol & w_rise) | (~r_intpol & w_fall)) & ~r_dir;

  // A fresh event beats a simultaneous software clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_intstat <= '0;
    else          r_intstat <= w_ev | (r_intstat & ~w_w1c);
  end

  always_comb begin
    w_rdmux = '0;
    case (r_addr[4:2])
      3'd0:    w_rdmux[GPIO_WIDTH-1:0] = r_dout;
      3'd1:    w_rdmux[GPIO_WIDTH-1:0] = r_dir;
      3'd2:    w_rdmux[GPIO_WIDTH-1:0] = w_din;
      3'd3:    w_rdmux[GPIO_WIDTH-1:0] = r_inten;
      3'd4:    w_rdmux[GPIO_WIDTH-1:0] = r_intpol;
      3'd5:    w_rdmux[GPIO_WIDTH-1:0] = r_intstat;
      default: w_rdmux = '0;
    endcase
  end

  assign ahb.HRDATA    = (r_valid && !r_write) ? w_rdmux : 32'h0;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign GPIOOUT       = r_dout;
  assign GPIOOE        = r_dir;
  assign GPIOINT       = |(r_intstat & r_inten);

  assign w_unused = ^{ahb.HADDR[31:5], ahb.HTRANS[0], ahb.HWDATA, w_bmask32, r_size[2]};

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Directed self-checking bench for ahb_gpio_param (GPIO_WIDTH=16, SYNC_STAGES=2).
module tb_ahb_gpio_param;

  logic        HCLK;
  logic        HRESETn;
  logic [15:0] gpioIn;
  logic [15:0] gpioOut;
  logic [15:0] gpioOe;
  logic        gpioInt;
  int          checkCount;
  int          errorCount;
  logic [31:0] rdData;

  ahb_gpio_param_if bus ();

  ahb_gpio_param #(.GPIO_WIDTH(16), .SYNC_STAGES(2)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus.slave),
    .GPIOIN  (gpioIn),
    .GPIOOUT (gpioOut),
    .GPIOOE  (gpioOe),
    .GPIOINT (gpioInt)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic busIdle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HADDR  = 32'h0;
  endtask

  task automatic addrPhase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  task automatic ahbWrite(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    addrPhase(addr, 1'b1, size);
    @(posedge HCLK); #1;
    busIdle();
    bus.HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahbRead(input logic [31:0] addr, output logic [31:0] data);
    addrPhase(addr, 1'b0, 3'd2);
    @(posedge HCLK); #1;
    busIdle();
    data = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    ahbRead(addr, d);
    checkOutput(tag, d, expected);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    HRESETn    = 1'b0;
    gpioIn     = 16'h0;
    bus.HWDATA = 32'h0;
    busIdle();

    // Reset values
    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("rst_oe",     32'(gpioOe),        32'h0);
    checkOutput("rst_out",    32'(gpioOut),       32'h0);
    checkOutput("rst_int",    32'(gpioInt),       32'h0);
    checkOutput("rst_ready",  32'(bus.HREADYOUT), 32'h1);
    checkOutput("rst_resp",   32'(bus.HRESP),     32'h0);
    checkOutput("rst_rdata",  bus.HRDATA,         32'h0);
    HRESETn = 1'b1;
    waitEdges(1);
    for (int a = 0; a < 8; a++) begin
      ahbRead(32'(a * 4), rdData);
      checkOutput($sformatf("rst_reg%0d", a), rdData, 32'h0);
      checkOutput($sformatf("rst_ready%0d", a), 32'(bus.HREADYOUT), 32'h1);
    end

    // DIR/DOUT, with a read issued back-to-back behind the DOUT write
    ahbWrite(32'h04, 3'd2, 32'h000000FF);
    addrPhase(32'h00, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    addrPhase(32'h00, 1'b0, 3'd2);
    bus.HWDATA = 32'h0000A5A5;
    @(posedge HCLK); #1;
    busIdle();
    checkOutput("b2b_dout", bus.HRDATA, 32'h0000A5A5);
    @(posedge HCLK); #1;
    checkOutput("idle_rdata", bus.HRDATA, 32'h0);
    checkOutput("oe_ff",    32'(gpioOe),  32'h000000FF);
    checkOutput("out_a5a5", 32'(gpioOut), 32'h0000A5A5);
    readCheck("rd_dir",  32'h04, 32'h000000FF);
    readCheck("rd_dout", 32'h00, 32'h0000A5A5);

    // Byte lane and above-width behaviour
    ahbWrite(32'h00, 3'd2, 32'h00001111);
    ahbWrite(32'h01, 3'd0, 32'h00003C00);
    checkOutput("byte_lane1", 32'(gpioOut), 32'h00003C11);
    ahbWrite(32'h02, 3'd1, 32'hBEEF0000);
    checkOutput("half_hi_ign", 32'(gpioOut), 32'h00003C11);
    readCheck("rd_dout_3c11", 32'h00, 32'h00003C11);
    ahbWrite(32'h10, 3'd2, 32'hFFFFFFFF);
    readCheck("rd_pol_trunc", 32'h10, 32'h0000FFFF);
    ahbWrite(32'h18, 3'd2, 32'hFFFFFFFF);
    readCheck("rd_0x18", 32'h18, 32'h0);
    readCheck("rd_0x1c", 32'h1C, 32'h0);

    // Rising edge on pin 0 reaches INTSTAT after SYNC_STAGES+1 edges
    ahbWrite(32'h04, 3'd2, 32'h0);
    ahbWrite(32'h10, 3'd2, 32'h1);
    ahbWrite(32'h0C, 3'd2, 32'h1);
    gpioIn[0] = 1'b1;
    waitEdges(1);
    checkOutput("int_e1", 32'(gpioInt), 32'h0);
    waitEdges(1);
    checkOutput("int_e2", 32'(gpioInt), 32'h0);
    waitEdges(1);
    checkOutput("int_e3", 32'(gpioInt), 32'h1);
    readCheck("stat_set", 32'h14, 32'h1);
    readCheck("din_bit0", 32'h08, 32'h1);

    // W1C clear drops GPIOINT on the edge ending the data phase
    addrPhase(32'h14, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    checkOutput("clr_hold", 32'(gpioInt), 32'h1);
    busIdle();
    bus.HWDATA = 32'h1;
    @(posedge HCLK); #1;
    checkOutput("clr_drop", 32'(gpioInt), 32'h0);
    readCheck("stat_clr", 32'h14, 32'h0);

    // Falling edge with rising polarity sets nothing
    gpioIn[0] = 1'b0;
    waitEdges(4);
    readCheck("fall_none", 32'h14, 32'h0);
    checkOutput("fall_int", 32'(gpioInt), 32'h0);

    // New event coincides with the clear: flag stays set
    gpioIn[0] = 1'b1;
    waitEdges(3);
    checkOutput("reup_int", 32'(gpioInt), 32'h1);
    gpioIn[0] = 1'b0;
    waitEdges(4);
    gpioIn[0] = 1'b1;
    waitEdges(1);
    addrPhase(32'h14, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    busIdle();
    bus.HWDATA = 32'h1;
    @(posedge HCLK); #1;
    checkOutput("collide_int", 32'(gpioInt), 32'h1);
    readCheck("collide_stat", 32'h14, 32'h1);
    ahbWrite(32'h14, 3'd2, 32'h1);
    checkOutput("final_clr_int", 32'(gpioInt), 32'h0);
    readCheck("final_clr_stat", 32'h14, 32'h0);

    // Output pins never raise events
    ahbWrite(32'h04, 3'd2, 32'h8);
    ahbWrite(32'h10, 3'd2, 32'h9);
    ahbWrite(32'h0C, 3'd2, 32'h9);
    gpioIn[3] = 1'b1;
    waitEdges(4);
    gpioIn[3] = 1'b0;
    waitEdges(4);
    readCheck("outpin_stat", 32'h14, 32'h0);
    checkOutput("outpin_int", 32'(gpioInt), 32'h0);

    // Reset asserted during a write data phase
    addrPhase(32'h00, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    busIdle();
    bus.HWDATA = 32'h0000FFFF;
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_out",   32'(gpioOut),       32'h0);
    checkOutput("mid_rst_oe",    32'(gpioOe),        32'h0);
    checkOutput("mid_rst_int",   32'(gpioInt),       32'h0);
    checkOutput("mid_rst_ready", 32'(bus.HREADYOUT), 32'h1);
    checkOutput("mid_rst_rdata", bus.HRDATA,         32'h0);
    waitEdges(1);
    checkOutput("mid_rst_out2", 32'(gpioOut), 32'h0);
    HRESETn = 1'b1;
    waitEdges(1);
    readCheck("post_rst_dout",  32'h00, 32'h0);
    readCheck("post_rst_dir",   32'h04, 32'h0);
    readCheck("post_rst_inten", 32'h0C, 32'h0);
    readCheck("post_rst_pol",   32'h10, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
